// File: rtl/irq_ctrl.sv
// Priority interrupt controller: masks and prioritises level requests, presents one
// request plus cause code to the core, and acknowledges the serviced line on return.
module irq_ctrl #(
  parameter int          N_IRQ      = 16,
  parameter logic [31:0] CAUSE_BASE = 32'h8000_0010
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] irq_req_i,
  output logic [N_IRQ-1:0] irq_ret_o,
  output logic             core_irq_req_o,
  output logic [31:0]      core_irq_cause_o,
  input  logic             core_irq_ret_i,
  input  logic             req_i,
  input  logic             write_enable_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      write_data_i,
  output logic [31:0]      read_data_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] ret_q, ret_d;
  logic [3:0]       id_q, id_d;
  logic             core_req_q, core_req_d;
  logic [31:0]      cause_q, cause_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [N_IRQ-1:0] pending_s;
  logic [3:0]       win_s;
  logic [31:0]      rd_mux_s;
  logic             bus_wr_s;
  logic             bus_rd_s;
  logic             unused_s;

  // Lowest set bit wins; scanning downwards leaves the lowest index last.
  function automatic logic [3:0] lowest_set(input logic [N_IRQ-1:0] vec);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      idx = vec[i] ? 4'(i) : idx;
    end
    return idx;
  endfunction

  assign unused_s = ^write_data_i;

  // Bus decode, register window and pending/winner computation.
  always_comb begin
    pending_s = irq_req_i & mask_q;
    win_s     = lowest_set(pending_s);
    bus_wr_s  = req_i & write_enable_i;
    bus_rd_s  = req_i & ~write_enable_i;

    case (addr_i)
      32'h0000_0000: rd_mux_s = 32'(mask_q);
      32'h0000_0004: rd_mux_s = 32'(pending_s);
      32'h0000_0008: rd_mux_s = {(state_q != IDLE), 27'd0, id_q};
      default:       rd_mux_s = 32'd0;
    endcase

    if (bus_wr_s && (addr_i == 32'h0000_0000)) begin
      mask_d = write_data_i[N_IRQ-1:0];
    end else begin
      mask_d = mask_q;
    end

    if (bus_rd_s) begin
      rdata_d = rd_mux_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Arbitration FSM next-state; the request is held through BUSY regardless of inputs.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    core_req_d = core_req_q;
    cause_d    = cause_q;
    ret_d      = {N_IRQ{1'b0}};

    case (state_q)
      IDLE: begin
        if (|pending_s) begin
          id_d       = win_s;
          cause_d    = CAUSE_BASE + {28'd0, win_s};
          core_req_d = 1'b1;
          state_d    = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (core_irq_ret_i) begin
          core_req_d = 1'b0;
          for (int i = 0; i < N_IRQ; i++) begin
            ret_d[i] = (id_q == 4'(i));
          end
          state_d = ACK;
        end else begin
          state_d = BUSY;
        end
      end
      ACK: begin
        core_req_d = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        core_req_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      mask_q     <= {N_IRQ{1'b0}};
      ret_q      <= {N_IRQ{1'b0}};
      id_q       <= 4'd0;
      core_req_q <= 1'b0;
      cause_q    <= 32'd0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      ret_q      <= ret_d;
      id_q       <= id_d;
      core_req_q <= core_req_d;
      cause_q    <= cause_d;
      rdata_q    <= rdata_d;
    end
  end

  assign irq_ret_o        = ret_q;
  assign core_irq_req_o   = core_req_q;
  assign core_irq_cause_o = cause_q;
  assign read_data_o      = rdata_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed, table-driven bench for irq_ctrl plus hand-written reset sequences.
module tb_irq_ctrl;

  localparam logic [31:0] C = 32'h8000_0010;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] irq_req_i = 16'h0000;
  logic [15:0] irq_ret_o;
  logic        core_irq_req_o;
  logic [31:0] core_irq_cause_o;
  logic        core_irq_ret_i = 1'b0;
  logic        req_i = 1'b0;
  logic        write_enable_i = 1'b0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] write_data_i = 32'd0;
  logic [31:0] read_data_o;

  int n_cmp = 0;
  int n_err = 0;

  irq_ctrl #(.N_IRQ(16), .CAUSE_BASE(32'h8000_0010)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .irq_req_i(irq_req_i), .irq_ret_o(irq_ret_o),
    .core_irq_req_o(core_irq_req_o), .core_irq_cause_o(core_irq_cause_o),
    .core_irq_ret_i(core_irq_ret_i), .req_i(req_i), .write_enable_i(write_enable_i),
    .addr_i(addr_i), .write_data_i(write_data_i), .read_data_o(read_data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        bus_req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [15:0] irq;
    logic        ret;
    logic        exp_req;
    logic [31:0] exp_cause;
    logic [15:0] exp_ret;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic br, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [15:0] irq, input logic ret,
                              input logic er, input logic [31:0] ec, input logic [15:0] et,
                              input logic [31:0] erd);
    vec_t v;
    v.bus_req = br; v.we = we; v.addr = a; v.wdata = wd; v.irq = irq; v.ret = ret;
    v.exp_req = er; v.exp_cause = ec; v.exp_ret = et; v.exp_rd = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic br, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [15:0] irq, input logic ret);
    req_i = br; write_enable_i = we; addr_i = a; write_data_i = wd;
    irq_req_i = irq; core_irq_ret_i = ret;
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk_i);
    drive(v.bus_req, v.we, v.addr, v.wdata, v.irq, v.ret);
    @(posedge clk_i);
    #1;
    chk({tag, " core_req"}, 32'(core_irq_req_o), 32'(v.exp_req));
    chk({tag, " cause"}, core_irq_cause_o, v.exp_cause);
    chk({tag, " irq_ret"}, 32'(irq_ret_o), 32'(v.exp_ret));
    chk({tag, " rdata"}, read_data_o, v.exp_rd);
  endtask

  initial begin
    //          br    we    addr   wdata      irq       ret   req   cause   ret_o     rdata
    vecs.push_back(mk(1'b1, 1'b0, 32'h04, 32'h0,    16'h0003, 1'b0, 1'b0, 32'h0, 16'h0000, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 32'h00, 32'h3,    16'h0003, 1'b0, 1'b0, 32'h0, 16'h0000, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,    16'h0003, 1'b0, 1'b1, C,     16'h0000, 32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h08, 32'h0,    16'h0003, 1'b0, 1'b1, C,     16'h0000, 32'h8000_0000));
    vecs.push_back(mk(1'b1, 1'b0, 32'h00, 32'h0,    16'h0003, 1'b0, 1'b1, C,     16'h0000, 32'h3));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,    16'h0003, 1'b1, 1'b0, C,     16'h0001, 32'h3));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,    16'h0002, 1'b0, 1'b0, C,     16'h0000, 32'h3));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,    16'h0002, 1'b0, 1'b1, C+1,   16'h0000, 32'h3));
    vecs.push_back(mk(1'b1, 1'b0, 32'h04, 32'h0,    16'h0002, 1'b0, 1'b1, C+1,   16'h0000, 32'h2));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,    16'h0000, 1'b1, 1'b0, C+1,   16'h0002, 32'h2));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,    16'h0000, 1'b0, 1'b0, C+1,   16'h0000, 32'h2));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,    16'h0000, 1'b1, 1'b0, C+1,   16'h0000, 32'h2));
    vecs.push_back(mk(1'b1, 1'b0, 32'h08, 32'h0,    16'h0000, 1'b0, 1'b0, C+1,   16'h0000, 32'h1));
    vecs.push_back(mk(1'b1, 1'b1, 32'h00, 32'hFFFF, 16'h0000, 1'b0, 1'b0, C+1,   16'h0000, 32'h1));
    vecs.push_back(mk(1'b1, 1'b1, 32'h04, 32'h0,    16'h0000, 1'b0, 1'b0, C+1,   16'h0000, 32'h1));
    vecs.push_back(mk(1'b1, 1'b1, 32'h0C, 32'h0,    16'h0000, 1'b0, 1'b0, C+1,   16'h0000, 32'h1));
    vecs.push_back(mk(1'b1, 1'b0, 32'h10, 32'h0,    16'h0000, 1'b0, 1'b0, C+1,   16'h0000, 32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h00, 32'h0,    16'h0000, 1'b0, 1'b0, C+1,   16'h0000, 32'hFFFF));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,    16'h0004, 1'b0, 1'b1, C+2,   16'h0000, 32'hFFFF));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,    16'h0005, 1'b0, 1'b1, C+2,   16'h0000, 32'hFFFF));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,    16'h0005, 1'b1, 1'b0, C+2,   16'h0004, 32'hFFFF));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,    16'h0001, 1'b0, 1'b0, C+2,   16'h0000, 32'hFFFF));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,    16'h0001, 1'b0, 1'b1, C,     16'h0000, 32'hFFFF));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,    16'h0001, 1'b1, 1'b0, C,     16'h0001, 32'hFFFF));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,    16'h0003, 1'b0, 1'b0, C,     16'h0000, 32'hFFFF));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,    16'h0003, 1'b0, 1'b1, C,     16'h0000, 32'hFFFF));
    vecs.push_back(mk(1'b1, 1'b1, 32'h00, 32'h0,    16'h0003, 1'b0, 1'b1, C,     16'h0000, 32'hFFFF));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,    16'h0003, 1'b1, 1'b0, C,     16'h0001, 32'hFFFF));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,    16'h0003, 1'b0, 1'b0, C,     16'h0000, 32'hFFFF));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,    16'h0003, 1'b0, 1'b0, C,     16'h0000, 32'hFFFF));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, 32'h0,    16'h0003, 1'b0, 1'b0, C,     16'h0000, 32'hFFFF));
    vecs.push_back(mk(1'b1, 1'b0, 32'h00, 32'h0,    16'h0003, 1'b0, 1'b0, C,     16'h0000, 32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 32'h04, 32'h0,    16'h0003, 1'b0, 1'b0, C,     16'h0000, 32'h0));

    // Reset state while rst_i is held.
    #12;
    chk("rst core_req", 32'(core_irq_req_o), 32'd0);
    chk("rst cause", core_irq_cause_o, 32'd0);
    chk("rst irq_ret", 32'(irq_ret_o), 32'd0);
    chk("rst rdata", read_data_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Masked lines never raise a request.
    for (int i = 0; i < 20; i++) begin
      apply(mk(1'b0, 1'b0, 32'h0, 32'h0, 16'h0003, 1'b0, 1'b0, 32'h0, 16'h0000, 32'h0),
            $sformatf("masked%0d", i));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("v%0d", i));
    end

    // Asynchronous reset in the middle of BUSY.
    apply(mk(1'b1, 1'b1, 32'h00, 32'h1, 16'h0001, 1'b0, 1'b0, C, 16'h0000, 32'h0), "rb_wr");
    apply(mk(1'b0, 1'b0, 32'h00, 32'h0, 16'h0001, 1'b0, 1'b1, C, 16'h0000, 32'h0), "rb_busy");
    #2;
    rst_i = 1'b1;
    #1;
    chk("rb core_req", 32'(core_irq_req_o), 32'd0);
    chk("rb irq_ret", 32'(irq_ret_o), 32'd0);
    chk("rb cause", core_irq_cause_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    apply(mk(1'b1, 1'b0, 32'h00, 32'h0, 16'h0001, 1'b0, 1'b0, 32'h0, 16'h0000, 32'h0), "rb_mask");

    // Asynchronous reset while the acknowledge pulse is out.
    apply(mk(1'b1, 1'b1, 32'h00, 32'h1, 16'h0001, 1'b0, 1'b0, 32'h0, 16'h0000, 32'h0), "ra_wr");
    apply(mk(1'b0, 1'b0, 32'h00, 32'h0, 16'h0001, 1'b0, 1'b1, C, 16'h0000, 32'h0), "ra_busy");
    apply(mk(1'b0, 1'b0, 32'h00, 32'h0, 16'h0001, 1'b1, 1'b0, C, 16'h0001, 32'h0), "ra_ack");
    #2;
    rst_i = 1'b1;
    #1;
    chk("ra irq_ret", 32'(irq_ret_o), 32'd0);
    chk("ra core_req", 32'(core_irq_req_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    apply(mk(1'b1, 1'b0, 32'h00, 32'h0, 16'h0000, 1'b0, 1'b0, 32'h0, 16'h0000, 32'h0), "ra_mask");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
